int_arb_tree: RTL and testbench
===============================

INT_ARB_TREE -- requirements
Module: int_arb_tree

Interface
REQ-001 The block SHALL have parameter IntAmount, default 8, meaning the number of interrupt sources (minimum 2; any value, not only powers of two).
REQ-002 The block SHALL have parameter Priorities, default 4, meaning the number of priority levels; PrioWidth = $clog2(Priorities).
REQ-003 The block SHALL have derived parameter IdWidth = $clog2(IntAmount), and derived parameter Levels = $clog2(IntAmount).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port advance, input, 1 bit: when high, the pipeline moves one stage; when low, all stage registers hold.
REQ-007 The block SHALL have port prio_i, input, IntAmount x PrioWidth: the priority of each source; a higher value is more urgent.
REQ-008 The block SHALL have ports pending_i and enabled_i, input, each IntAmount x 1: the per-source pending and enable flags.
REQ-009 The block SHALL have port threshold_i, input, PrioWidth: the winner must be strictly above this value.
REQ-010 The block SHALL have port id_o, output, IdWidth: the winning source index.
REQ-011 The block SHALL have port prio_o, output, PrioWidth: the winning priority.
REQ-012 The block SHALL have port valid_o, output, 1 bit: id_o and prio_o are meaningful.

Function
REQ-013 A source SHALL be eligible iff pending_i & enabled_i.
REQ-014 Leaf padding to 2^Levels SHALL use ineligible entries with prio 0; padded entries SHALL never win.
REQ-015 Each tree node SHALL select the eligible child with the higher prio.
REQ-016 On equal priority at a node, the lower index SHALL win.
REQ-017 When only one child of a node is eligible, that child SHALL win regardless of prio.
REQ-018 A node SHALL be eligible iff either child is eligible.
REQ-019 valid_o SHALL equal root eligible AND (root prio > threshold_i).
REQ-020 threshold_i SHALL be sampled at the final stage, in the same cycle as the root result it gates.
REQ-021 When valid_o is 0, id_o and prio_o SHALL be 0.
REQ-022 When advance = 0, the outputs and every stage register SHALL hold their values; input changes during that time SHALL be ignored.
REQ-023 Successive input vectors presented with advance = 1 SHALL produce results at full throughput (one result per cycle), in order.
REQ-024 When no source is eligible, valid_o SHALL be 0 after the latency.

Reset
REQ-025 Asserting reset SHALL immediately clear all stage registers and all outputs (id_o = 0, prio_o = 0, valid_o = 0), independent of clk.
REQ-026 Reset applied mid-operation SHALL discard all in-flight results.
REQ-027 After reset deassertion, valid_o SHALL remain 0 until the first vector has traversed the full latency with advance = 1.

Configuration
REQ-028 The macro INT_ARB_TREE_PIPE_EN SHALL control pipelining.
REQ-029 With INT_ARB_TREE_PIPE_EN defined, a register SHALL follow every tree level, giving latency Levels cycles (3 for IntAmount = 8).
REQ-030 Without INT_ARB_TREE_PIPE_EN, the tree SHALL be fully combinational with only the output register, giving latency 1 cycle.
REQ-031 The functional result SHALL be identical in both builds; only the latency differs.

Verification
REQ-032 Scenario, basic arbitration: prio = {3,3,2,1,3,0,2,3}, enabled = {1,0,0,1,1,0,1,0}, pending = {0,1,1,0,1,0,1,0}, threshold = 0, advance = 1 -> id_o = 4, prio_o = 3, valid_o = 1 after 3 cycles (pipe build) or 1 cycle (non-pipe build).
REQ-033 Scenario, threshold: same vectors with threshold = 3 -> valid_o = 0, id_o = 0. With threshold = 2 -> id_o = 4, valid_o = 1.
REQ-034 Scenario, tie-break and IntAmount = 5: all sources eligible, all prio = 2, threshold = 0 -> id_o = 0. Then disable source 0 only -> id_o = 1.
REQ-035 Scenario, stall and throughput: drive three distinct vectors back-to-back, dropping advance for 2 cycles midway -> three results emerge in order, held unchanged during the stall.
REQ-036 Scenario, reset mid-flight: assert reset between clock edges while the pipeline holds valid data -> all outputs are 0 immediately; no stale result appears after release.
REQ-037 Scenario, nothing eligible: all pending = 0 -> valid_o = 0 continuously.

Source files
------------

// File: rtl/int_arb_tree.sv
// rtl/int_arb_tree.sv - binary priority-arbitration tree selecting the most urgent eligible interrupt source
// Define INT_ARB_TREE_PIPE_EN to register every tree level (latency Levels); otherwise latency is 1 cycle.
module int_arb_tree #(
    parameter int  IntAmount  = 8,
    parameter int  Priorities = 4,
    localparam int PrioWidth  = $clog2(Priorities),
    localparam int IdWidth    = $clog2(IntAmount),
    localparam int Levels     = $clog2(IntAmount)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                advance,
    input  logic [IntAmount-1:0][PrioWidth-1:0] prio_i,
    input  logic [IntAmount-1:0]                pending_i,
    input  logic [IntAmount-1:0]                enabled_i,
    input  logic [PrioWidth-1:0]                threshold_i,
    output logic [IdWidth-1:0]                  id_o,
    output logic [PrioWidth-1:0]                prio_o,
    output logic                                valid_o
);

    localparam int NumLeaves = 1 << Levels;

    typedef struct packed {
        logic                 vld;
        logic [IdWidth-1:0]   id;
        logic [PrioWidth-1:0] prio;
    } node_t;

    logic [NumLeaves-1:0]                elig_pad;
    logic [NumLeaves-1:0][PrioWidth-1:0] prio_pad;
    node_t                               node_c [1:2*NumLeaves-1];
    node_t                               root;
    logic                                valid_d;
    logic                                valid_q;
    logic [IdWidth-1:0]                  id_d;
    logic [IdWidth-1:0]                  id_q;
    logic [PrioWidth-1:0]                prio_d;
    logic [PrioWidth-1:0]                prio_q;

`ifdef INT_ARB_TREE_PIPE_EN
    node_t                               stage_d [1:NumLeaves-1];
    node_t                               stage_q [1:NumLeaves-1];
`endif

    // Padding leaves are ineligible with prio 0, so they can never win a node.
    always_comb begin
        elig_pad                = '0;
        prio_pad                = '0;
        elig_pad[IntAmount-1:0] = pending_i & enabled_i;
        prio_pad[IntAmount-1:0] = prio_i;
    end

    // Heap layout: node k has children 2k (lower indices) and 2k+1; leaves start at NumLeaves.
    always_comb begin : tree
        node_t left;
        node_t right;
        left  = '0;
        right = '0;
        for (int i = 0; i < NumLeaves; i++) begin
            node_c[NumLeaves + i] = '{vld: elig_pad[i], id: IdWidth'(i), prio: prio_pad[i]};
        end
        for (int k = NumLeaves - 1; k >= 1; k--) begin
            left  = node_c[2*k];
            right = node_c[2*k + 1];
`ifdef INT_ARB_TREE_PIPE_EN
            if (2*k < NumLeaves) begin
                left  = stage_q[2*k];
                right = stage_q[2*k + 1];
            end
`endif
            // Left child holds the lower indices, so it keeps ties.
            if (left.vld && right.vld) begin
                node_c[k] = (right.prio > left.prio) ? right : left;
            end else if (right.vld) begin
                node_c[k] = right;
            end else begin
                node_c[k] = left;
            end
        end
        root = node_c[1];
    end

`ifdef INT_ARB_TREE_PIPE_EN
    always_comb begin
        for (int k = 1; k < NumLeaves; k++) begin
            stage_d[k] = node_c[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k < NumLeaves; k++) begin
                stage_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 1; k < NumLeaves; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end
`endif

    // Threshold gates the root in the same cycle the root result is captured.
    always_comb begin
        valid_d = root.vld && (root.prio > threshold_i);
        id_d    = valid_d ? root.id   : '0;
        prio_d  = valid_d ? root.prio : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            prio_q  <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end

    assign valid_o = valid_q;
    assign id_o    = id_q;
    assign prio_o  = prio_q;

endmodule

// File: tb/tb_int_arb_tree.sv
// tb/tb_int_arb_tree.sv - directed self-checking bench for int_arb_tree (IntAmount 8 and 5)
module tb_int_arb_tree;

`ifdef INT_ARB_TREE_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            advance;
    logic [1:0]      thr;
    logic [7:0][1:0] prio8;
    logic [7:0]      pend8;
    logic [7:0]      en8;
    logic [2:0]      id8;
    logic [1:0]      p8;
    logic            v8;
    logic [4:0][1:0] prio5;
    logic [4:0]      pend5;
    logic [4:0]      en5;
    logic [2:0]      id5;
    logic [1:0]      p5;
    logic            v5;

    int              n_vec;
    int              n_err;
    logic [5:0]      pipe [$];

    always #5 clk = ~clk;

    int_arb_tree #(.IntAmount(8), .Priorities(4)) dut (
        .clk(clk), .reset(reset), .advance(advance), .prio_i(prio8),
        .pending_i(pend8), .enabled_i(en8), .threshold_i(thr),
        .id_o(id8), .prio_o(p8), .valid_o(v8)
    );

    int_arb_tree #(.IntAmount(5), .Priorities(4)) dut5 (
        .clk(clk), .reset(reset), .advance(advance), .prio_i(prio5),
        .pending_i(pend5), .enabled_i(en5), .threshold_i(thr),
        .id_o(id5), .prio_o(p5), .valid_o(v5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock edge; when advancing, the expected result r enters the model pipeline.
    task automatic tick(input logic [5:0] r);
        step();
        if (advance) begin
            pipe.push_front(r);
            void'(pipe.pop_back());
        end
        check("stream", {26'd0, v8, id8, p8}, {26'd0, pipe[LAT-1]});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        advance = 1'b0;
        thr     = 2'd0;
        // prio index 0..7 = 3,3,2,1,3,0,2,3 (written index 7 first)
        prio8   = {2'd3, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd3};
        pend8   = 8'h00;
        en8     = 8'h00;
        prio5   = '0;
        pend5   = '0;
        en5     = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", v8, 0);
        check("rst_id", id8, 0);
        check("rst_prio", p8, 0);
        check("rst_valid5", v5, 0);
        step();
        #2 reset = 1'b0;

        // basic arbitration: eligible sources 4 (prio 3) and 6 (prio 2)
        advance = 1'b1;
        en8     = 8'b0101_1001;
        pend8   = 8'b0101_0110;
        repeat (LAT - 1) begin
            step();
            check("latency_valid", v8, 0);
        end
        step();
        check("basic_id", id8, 4);
        check("basic_prio", p8, 3);
        check("basic_valid", v8, 1);

        thr = 2'd3;
        step();
        check("thr3_valid", v8, 0);
        check("thr3_id", id8, 0);
        check("thr3_prio", p8, 0);
        thr = 2'd2;
        step();
        check("thr2_id", id8, 4);
        check("thr2_valid", v8, 1);
        thr = 2'd0;

        // a lone eligible source at prio 0 is not strictly above threshold 0
        en8   = 8'hFF;
        pend8 = 8'b0010_0000;
        repeat (LAT) step();
        check("prio0_valid", v8, 0);

        // IntAmount 5: tie-break, then source 0 disabled, then only the last source
        prio5 = {5{2'd2}};
        pend5 = 5'b11111;
        en5   = 5'b11111;
        repeat (LAT) step();
        check("tie_id", id5, 0);
        check("tie_prio", p5, 2);
        check("tie_valid", v5, 1);
        en5 = 5'b11110;
        repeat (LAT) step();
        check("dis0_id", id5, 1);
        en5      = 5'b10000;
        prio5[4] = 2'd1;
        repeat (LAT) step();
        check("last_id", id5, 4);
        check("last_prio", p5, 1);
        check("last_valid", v5, 1);

        // stall/throughput: pipeline currently holds only invalid results
        pipe.delete();
        repeat (LAT) pipe.push_back(6'd0);
        pend8 = 8'b0000_0010;
        tick({1'b1, 3'd1, 2'd3});
        pend8 = 8'b1010_0000;
        tick({1'b1, 3'd7, 2'd3});
        advance = 1'b0;
        pend8   = 8'hFF;
        tick({1'b1, 3'd0, 2'd3});
        tick({1'b1, 3'd0, 2'd3});
        advance = 1'b1;
        pend8   = 8'b0100_0100;
        tick({1'b1, 3'd2, 2'd2});
        pend8 = 8'h00;
        repeat (LAT) tick(6'd0);

        // reset mid-flight, between clock edges
        en8   = 8'b0101_1001;
        pend8 = 8'b0101_0110;
        repeat (LAT) step();
        check("pre_rst_valid", v8, 1);
        en8   = 8'hFF;
        pend8 = 8'b0000_0010;
        step();
        #3 reset = 1'b1;
        #1;
        check("midrst_valid", v8, 0);
        check("midrst_id", id8, 0);
        check("midrst_prio", p8, 0);
        pend8 = 8'h00;
        step();
        #2 reset = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            check("idle_valid", v8, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
